// File: rtl/lsu_dmem_if.sv
// Request/response bundle between the pipeline and the data-memory LSU.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// rsp_valid is a one-cycle strobe with no back-pressure, and rsp_rdata/rsp_fault are 0 whenever rsp_valid is 0.
interface lsu_dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/lsu_dmem.sv
// Load/store unit with internal little-endian doubleword storage.
// One request per three cycles: IDLE (accept) -> ACCESS (read/write) -> RESP (strobe).
module lsu_dmem #(
  parameter int DEPTH = 64
) (
  input  logic           clk,
  input  logic           reset,
  lsu_dmem_if.slave      bus,
  output logic [1:0]     dbg_state
);

  localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          AW    = IDX_W + 3;
  localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic [63:0] mem [DEPTH];

  logic          wr_q;
  logic          signed_q;
  logic          fault_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [63:0]   wdata_q;

  logic          ready_q;
  logic          rsp_valid_q;
  logic          rsp_fault_q;
  logic [63:0]   rsp_rdata_q;

  logic          misaligned;
  logic          fault_in;
  logic [IDX_W-1:0] idx;
  logic [5:0]    sh;
  logic [63:0]   lane;
  logic [63:0]   load_val;
  logic [7:0]    be;
  logic [63:0]   wshift;

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = bus.req_addr[0];
      2'd2:    misaligned = |bus.req_addr[1:0];
      default: misaligned = |bus.req_addr[2:0];
    endcase
  end

  // Full 64-bit range compare so huge addresses never alias into storage.
  assign fault_in = misaligned || (bus.req_addr >= LIMIT);

  assign idx    = addr_q[AW-1:3];
  assign sh     = {addr_q[2:0], 3'b000};
  assign lane   = mem[idx] >> sh;
  assign wshift = wdata_q << sh;

  always_comb begin
    load_val = lane;
    be       = 8'hFF;
    case (size_q)
      2'd0: begin
        load_val = signed_q ? {{56{lane[7]}}, lane[7:0]} : {56'd0, lane[7:0]};
        be       = 8'h01 << addr_q[2:0];
      end
      2'd1: begin
        load_val = signed_q ? {{48{lane[15]}}, lane[15:0]} : {48'd0, lane[15:0]};
        be       = 8'h03 << addr_q[2:0];
      end
      2'd2: begin
        load_val = signed_q ? {{32{lane[31]}}, lane[31:0]} : {32'd0, lane[31:0]};
        be       = 8'h0F << addr_q[2:0];
      end
      default: begin
        load_val = lane;
        be       = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            wr_q     <= bus.req_write;
            signed_q <= bus.req_signed;
            size_q   <= bus.req_size;
            addr_q   <= bus.req_addr[AW-1:0];
            wdata_q  <= bus.req_wdata;
            fault_q  <= fault_in;
            ready_q  <= 1'b0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          state       <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_fault_q <= fault_q;
          rsp_rdata_q <= (fault_q || wr_q) ? 64'd0 : load_val;
        end
        RESP: begin
          state       <= IDLE;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 64'd0;
          rsp_fault_q <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 64'd0;
          rsp_fault_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; a reset during ACCESS gates the write off.
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && wr_q && !fault_q) begin
      for (int k = 0; k < 8; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wshift[8*k +: 8];
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign dbg_state     = state;

endmodule
